// File: rtl/decode_buffer_pkg.sv
// rtl/decode_buffer_pkg.sv - rv32i_types: opcode/funct3 enums and decoded-instruction record
package rv32i_types;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_FENCE  = 7'b0001111,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BR     = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'd0, F3_BNE  = 3'd1, F3_BLT  = 3'd4,
        F3_BGE  = 3'd5, F3_BLTU = 3'd6, F3_BGEU = 3'd7
    } branch_funct3_e;

    typedef enum logic [2:0] {
        F3_LB = 3'd0, F3_LH = 3'd1, F3_LW = 3'd2, F3_LBU = 3'd4, F3_LHU = 3'd5
    } load_funct3_e;

    typedef enum logic [2:0] {
        F3_SB = 3'd0, F3_SH = 3'd1, F3_SW = 3'd2
    } store_funct3_e;

    typedef enum logic [2:0] {
        F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3,
        F3_XOR = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7
    } arith_funct3_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        opcode_e     opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1_s;
        logic [4:0]  rs2_s;
        logic [4:0]  rd_s;
        logic [31:0] imm;
        logic        regf_we;
        logic        illegal;
    } dec_inst_t;

    function automatic logic is_rv32i_opcode(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_FENCE, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
            OP_LUI, OP_BR, OP_JALR, OP_JAL, OP_SYSTEM: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_buffer_if.sv
// rtl/decode_buffer_if.sv - fetch-side and rename-side handshakes of the decode buffer
interface decode_buffer_if;
    import rv32i_types::*;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    dec_inst_t   out_dec;

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_dec
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_dec
    );
endinterface

// File: rtl/rv32i_decoder.sv
// rtl/rv32i_decoder.sv - combinational RV32I field extraction and immediate selection
module rv32i_decoder
    import rv32i_types::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output dec_inst_t   dec
);

    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic        legal;

    assign i_imm = {{20{inst[31]}}, inst[31:20]};
    assign s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign u_imm = {inst[31:12], 12'b0};
    assign j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign legal = is_rv32i_opcode(inst[6:0]);

    always_comb begin
        dec         = '0;
        dec.pc      = pc;
        dec.inst    = inst;
        dec.opcode  = opcode_e'(inst[6:0]);
        dec.funct3  = inst[14:12];
        dec.funct7  = inst[31:25];
        dec.rs1_s   = inst[19:15];
        dec.rs2_s   = inst[24:20];
        dec.rd_s    = inst[11:7];
        dec.illegal = !legal;

        case (inst[6:0])
            OP_LUI, OP_AUIPC:       dec.imm = u_imm;
            OP_JAL:                 dec.imm = j_imm;
            OP_JALR, OP_LOAD, OP_IMM: dec.imm = i_imm;
            OP_BR:                  dec.imm = b_imm;
            OP_STORE:               dec.imm = s_imm;
            default:                dec.imm = '0;
        endcase

        // These formats reuse bits 24:20 as immediate, not a second source
        case (inst[6:0])
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM: dec.rs2_s = '0;
            default: ;
        endcase

        dec.regf_we = legal && (inst[6:0] != OP_BR) && (inst[6:0] != OP_STORE)
                      && (inst[11:7] != 5'd0);
    end

endmodule

// File: rtl/decode_buffer.sv
// rtl/decode_buffer.sv - fetch-to-rename instruction FIFO with decode at head; DECODE_BUF_BYPASS_EN enables empty-buffer bypass
module decode_buffer
    import rv32i_types::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    decode_buffer_if.slave   bus,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head, tail;
    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic             full, empty, bypass, push, pop;
    logic [31:0]      dec_pc, dec_inst;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

`ifdef DECODE_BUF_BYPASS_EN
    assign bypass   = empty && bus.in_valid && !flush;
    assign dec_pc   = bypass ? bus.in_pc   : pc_mem[head];
    assign dec_inst = bypass ? bus.in_inst : inst_mem[head];
`else
    assign bypass   = 1'b0;
    assign dec_pc   = pc_mem[head];
    assign dec_inst = inst_mem[head];
`endif

    assign bus.in_ready  = !full;
    assign bus.out_valid = (!empty && !flush) || bypass;

    // A bypassed instruction consumed the same cycle never touches storage
    assign push = bus.in_valid && !full && !flush && !(bypass && bus.out_ready);
    assign pop  = !empty && !flush && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[tail]   <= bus.in_pc;
            inst_mem[tail] <= bus.in_inst;
        end
    end

    rv32i_decoder u_decoder (
        .pc   (dec_pc),
        .inst (dec_inst),
        .dec  (bus.out_dec)
    );

endmodule

// File: doc/decode_buffer.md
DECODE_BUFFER -- requirements
Module: decode_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default $clog2(DEPTH)+1, meaning occupancy counter width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  discard all buffered instructions.
REQ-006 SHALL have port in_valid  input  1  fetch offers an instruction.
REQ-007 SHALL have port in_ready  output  1  buffer accepts this cycle.
REQ-008 SHALL have port in_pc  input  32  PC of offered instruction.
REQ-009 SHALL have port in_inst  input  32  raw instruction word.
REQ-010 SHALL have port out_valid  output  1  decoded instruction at head is valid.
REQ-011 SHALL have port out_ready  input  1  downstream (rename) consumes head.
REQ-012 SHALL have port out_dec  output  dec_inst_t  decoded head instruction.
REQ-013 SHALL have port count  output  CNT_W  current occupancy.

Function
REQ-014 SHALL push {in_pc,in_inst} at tail when in_valid && in_ready && !flush.
REQ-015 SHALL drive in_ready = (count != DEPTH); push into a full buffer is never accepted, even with a simultaneous pop.
REQ-016 SHALL drive out_valid = (count != 0) && !flush.
REQ-017 SHALL pop head when out_valid && out_ready.
REQ-018 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-019 SHALL wrap head/tail pointers modulo DEPTH.
REQ-020 SHALL give one-cycle latency: entry pushed at edge N is visible on out_dec after edge N.
REQ-021 SHALL decode out_dec combinationally from head entry: pc, inst, opcode, funct3, funct7, rs1_s, rs2_s, rd_s, imm, regf_we, illegal.
REQ-022 SHALL select imm by opcode: lui/auipc u_imm; jal j_imm; jalr/load/op_imm i_imm; br b_imm; store s_imm; otherwise 0.
REQ-023 SHALL force rs2_s = 0 for lui, auipc, jal, jalr, load, op_imm.
REQ-024 SHALL set regf_we = 0 for br, store, illegal, or rd_s == 0; otherwise 1.
REQ-025 SHALL set illegal = 1 for any opcode outside the RV32I base set.
REQ-026 SHALL, on flush, set count, head and tail to 0 at the next edge, ignoring same-cycle push and pop.

Reset
REQ-027 SHALL, under rst, set count=0, head=0, tail=0; out_valid=0, in_ready=1 the following cycle.
REQ-028 SHALL give rst priority over flush, push and pop; entry storage need not be cleared.

Configuration
REQ-029 SHALL, when DECODE_BUF_BYPASS_EN is defined, pass in_pc/in_inst straight to out_dec with out_valid=1 when count==0 && in_valid && !flush; if out_ready, nothing is written, else the entry is also pushed.
REQ-030 SHALL, without DECODE_BUF_BYPASS_EN, have no combinational path from in_* to out_*.

Structure
REQ-031 SHALL place dec_inst_t, the opcode enum and the funct3 enums in package rv32i_types.
REQ-032 SHALL implement field extraction in combinational sub-module rv32i_decoder (raw word + pc in, dec_inst_t out).

Verification
REQ-033 Reset, then push pc=0x60000000 inst=0x00500093 -> next cycle out_valid=1, rd_s=1, rs1_s=0, imm=5, regf_we=1, count=1.
REQ-034 Push 8 with out_ready=0 -> count=8, in_ready=0; 9th offer not accepted; pop 8 -> PCs emerge in order.
REQ-035 count=3, push and pop in the same cycle -> count stays 3; pointers wrap correctly across 20 such cycles.
REQ-036 Store 0x00112223 -> regf_we=0, imm=4, rs2_s=1; word 0x0000007F -> illegal=1, regf_we=0.
REQ-037 count=5, flush with in_valid=1 -> out_valid=0 that cycle; count=0 next; offered instruction lost.
REQ-038 With DECODE_BUF_BYPASS_EN, empty, in_valid=1, out_ready=1 -> out_valid=1 in the same cycle; count stays 0.
